double_framebuffer: RTL and testbench
=====================================

DOUBLE_FRAMEBUFFER -- requirements
Module: double_framebuffer

Interface
REQ-001 SHALL have parameter WIDTH, default 9, pixel word width in bits.
REQ-002 SHALL have parameter DEPTH, default 2048, words per bank; ADDR_WIDTH = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port resetN  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port writeEnable  input  1  drawing-side write strobe.
REQ-006 SHALL have port writeAddress  input  ADDR_WIDTH  back-buffer word address.
REQ-007 SHALL have port writeData  input  WIDTH  pixel to write.
REQ-008 SHALL have port writeReady  output  1  high when writes are accepted.
REQ-009 SHALL have port readEnable  input  1  display-side read strobe.
REQ-010 SHALL have port readAddress  input  ADDR_WIDTH  front-buffer word address.
REQ-011 SHALL have port readData  output  WIDTH  registered front-buffer word.
REQ-012 SHALL have port readValid  output  1  readData valid this cycle.
REQ-013 SHALL have port clearStart  input  1  start filling the back buffer.
REQ-014 SHALL have port clearValue  input  WIDTH  fill value, sampled with clearStart.
REQ-015 SHALL have port clearBusy  output  1  fill in progress.
REQ-016 SHALL have port clearDone  output  1  one-cycle pulse at fill completion.
REQ-017 SHALL have port swapRequest  input  1  request front/back exchange.
REQ-018 SHALL have port vsync  input  1  swap window (vertical blank) indicator.
REQ-019 SHALL have port swapPending  output  1  request accepted, not yet executed.
REQ-020 SHALL have port swapDone  output  1  one-cycle pulse when the swap executes.
REQ-021 SHALL have port frontSelect  output  1  index of the bank currently displayed.

Function
REQ-022 Two banks of DEPTH x WIDTH; front = bank[frontSelect], back = bank[~frontSelect].
REQ-023 Read: readEnable at cycle N -> readData = front[readAddress] and readValid = 1 at N+1; readValid = 0 otherwise; readData holds last value when not reading.
REQ-024 Read and swap in same cycle: read uses frontSelect value before the swap.
REQ-025 writeReady = 1 iff FSM in IDLE; write with writeEnable & writeReady stores writeData to back[writeAddress] at that edge; writes while writeReady = 0 are dropped.
REQ-026 Any address >= DEPTH (non-power-of-2 DEPTH): write ignored, read returns 0.
REQ-027 FSM states IDLE, CLEAR; IDLE + clearStart -> CLEAR, counter = 0, clearValue latched.
REQ-028 CLEAR: one back-buffer word written per cycle at counter, counter++; after writing DEPTH-1 -> IDLE with clearDone = 1 for that one cycle; fill takes exactly DEPTH cycles; clearBusy = 1 throughout CLEAR.
REQ-029 clearStart while in CLEAR ignored; write accepted in the same cycle as clearStart in IDLE is performed (then overwritten by the fill).
REQ-030 swapRequest sets swapPending at next edge; further requests while pending are absorbed (no queue).
REQ-031 Swap executes on the edge where swapPending & vsync & IDLE: frontSelect toggles, swapPending clears, swapDone = 1 for one cycle.
REQ-032 Swap is deferred while in CLEAR and executes on the first vsync cycle after returning to IDLE.
REQ-033 swapRequest in the same cycle as an executing swap is absorbed by that swap.

Reset
REQ-034 resetN low asynchronously forces: FSM IDLE, counter 0, frontSelect 0, swapPending 0, readData 0, readValid 0, clearDone 0, swapDone 0; clearBusy 0, writeReady 1 once released.
REQ-035 Reset during CLEAR aborts the fill; partially cleared contents remain; memory contents are never reset.

Structure
REQ-036 Package framebuffer_pkg SHALL hold the FSM state enum and bank-select constants.
REQ-037 Sub-module framebuffer_bank (single clock, one write port, one registered read port, WIDTH/DEPTH params) SHALL be instantiated twice; top-level muxes write/clear to back bank and read to front bank.

Verification
REQ-038 Write 0x1A5 to addr 5 with frontSelect = 0, request swap, pulse vsync -> frontSelect = 1, swapDone pulse; read addr 5 -> readData 0x1A5 one cycle later.
REQ-039 clearStart with clearValue 0x0FF -> clearBusy for 2048 cycles, clearDone once; reads of back after swap all return 0x0FF.
REQ-040 swapRequest + vsync held during clear -> no swap until clearDone; swap on first IDLE vsync cycle.
REQ-041 writeEnable during clear -> writeReady 0, target word keeps the fill value.
REQ-042 Assert resetN mid-clear at counter 100 -> all outputs at reset values, frontSelect 0, words 0..99 filled, word 100 onward unchanged.
REQ-043 Read addr 7 in the same cycle as the swap -> returns old front bank data.

Source files
------------

// File: rtl/framebuffer_pkg.sv
// Shared types and constants for the double-buffered frame store.
// Holds the fill FSM state encoding, bank-select constants and a helper
// that maps the displayed bank index to the drawing (back) bank index.
package framebuffer_pkg;

    localparam int unsigned NUM_BANKS = 2;

    // Bank-select values as seen on frontSelect
    localparam logic BANK0 = 1'b0;
    localparam logic BANK1 = 1'b1;

    // Fill sequencer states
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fbState_t;

    // The back bank is always the one not being displayed
    function automatic logic backOf(input logic front);
        return ~front;
    endfunction

endpackage

// File: rtl/framebuffer_bank.sv
// One DEPTH x WIDTH frame-store bank.
// Ports: clk, resetN (async, active-low; clears only the read register),
//        wrEn/wrAddr/wrData (one write port),
//        rdEn/rdAddr -> rdData (registered, holds when rdEn is low).
// Addresses at or above DEPTH are ignored on write and read back as zero.
module framebuffer_bank #(
    parameter  int unsigned WIDTH      = 9,
    parameter  int unsigned DEPTH      = 2048,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [WIDTH-1:0]      wrData,
    input  logic                  rdEn,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [WIDTH-1:0]      rdData
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wrInRange;
    logic             rdInRange;

    // Range checks only matter for non-power-of-two depths
    assign wrInRange = {1'b0, wrAddr} < (ADDR_WIDTH + 1)'(DEPTH);
    assign rdInRange = {1'b0, rdAddr} < (ADDR_WIDTH + 1)'(DEPTH);

    // Storage array: never reset, contents survive resetN
    always_ff @(posedge clk) begin
        if (wrEn && wrInRange) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= rdInRange ? mem[rdAddr] : '0;
        end
    end

endmodule

// File: rtl/double_framebuffer.sv
// Double-buffered frame store: the display reads the front bank while the
// drawing side writes (or bulk-fills) the back bank; a requested swap is
// executed during vsync once no fill is running.
// Ports: clk, resetN (async, active-low)
//        writeEnable/writeAddress/writeData, writeReady   -- back-buffer writes
//        readEnable/readAddress -> readData, readValid   -- front-buffer reads
//        clearStart/clearValue, clearBusy, clearDone      -- back-buffer fill
//        swapRequest, vsync, swapPending, swapDone        -- bank exchange
//        frontSelect                                      -- displayed bank
module double_framebuffer
    import framebuffer_pkg::*;
#(
    parameter  int unsigned WIDTH      = 9,
    parameter  int unsigned DEPTH      = 2048,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  writeEnable,
    input  logic [ADDR_WIDTH-1:0] writeAddress,
    input  logic [WIDTH-1:0]      writeData,
    output logic                  writeReady,
    input  logic                  readEnable,
    input  logic [ADDR_WIDTH-1:0] readAddress,
    output logic [WIDTH-1:0]      readData,
    output logic                  readValid,
    input  logic                  clearStart,
    input  logic [WIDTH-1:0]      clearValue,
    output logic                  clearBusy,
    output logic                  clearDone,
    input  logic                  swapRequest,
    input  logic                  vsync,
    output logic                  swapPending,
    output logic                  swapDone,
    output logic                  frontSelect
);

    fbState_t              state;
    fbState_t              stateNext;
    logic [ADDR_WIDTH-1:0] counter;
    logic [ADDR_WIDTH-1:0] counterNext;
    logic [WIDTH-1:0]      fillValue;
    logic                  lastWord;
    logic                  swapExec;

    logic                  backWrEn;
    logic [ADDR_WIDTH-1:0] backWrAddr;
    logic [WIDTH-1:0]      backWrData;
    logic [NUM_BANKS-1:0]  bankWrEn;
    logic [NUM_BANKS-1:0]  bankRdEn;
    logic [WIDTH-1:0]      bank0RdData;
    logic [WIDTH-1:0]      bank1RdData;
    logic                  readSel;

    assign lastWord = (counter == ADDR_WIDTH'(DEPTH - 1));
    // A swap only happens between fills, during the vertical blank
    assign swapExec = swapPending && vsync && (state == IDLE);

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
        end
    end

    // Next-state logic: a fill walks the whole back bank once
    always_comb begin
        stateNext   = state;
        counterNext = counter;
        case (state)
            IDLE: begin
                if (clearStart) begin
                    stateNext   = CLEAR;
                    counterNext = '0;
                end
            end
            CLEAR: begin
                if (lastWord) begin
                    stateNext   = IDLE;
                    counterNext = '0;
                end else begin
                    counterNext = counter + ADDR_WIDTH'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: the fill owns the back-bank write port while clearing
    always_comb begin
        backWrEn   = 1'b0;
        backWrAddr = writeAddress;
        backWrData = writeData;
        case (state)
            IDLE:  backWrEn = writeEnable;
            CLEAR: begin
                backWrEn   = 1'b1;
                backWrAddr = counter;
                backWrData = fillValue;
            end
            default: backWrEn = 1'b0;
        endcase
    end

    // Registered status, swap control and read bookkeeping
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fillValue   <= '0;
            writeReady  <= 1'b1;
            clearBusy   <= 1'b0;
            clearDone   <= 1'b0;
            swapPending <= 1'b0;
            swapDone    <= 1'b0;
            frontSelect <= BANK0;
            readValid   <= 1'b0;
            readSel     <= BANK0;
        end else begin
            writeReady <= (stateNext == IDLE);
            clearBusy  <= (stateNext == CLEAR);
            clearDone  <= (state == CLEAR) && lastWord;
            if ((state == IDLE) && clearStart) begin
                fillValue <= clearValue;
            end
            swapDone <= swapExec;
            // An executing swap also absorbs a request arriving on the same edge
            if (swapExec) begin
                frontSelect <= ~frontSelect;
                swapPending <= 1'b0;
            end else if (swapRequest) begin
                swapPending <= 1'b1;
            end
            readValid <= readEnable;
            if (readEnable) begin
                readSel <= frontSelect;
            end
        end
    end

    // Route writes to the back bank and reads to the pre-swap front bank
    always_comb begin
        bankWrEn                      = '0;
        bankRdEn                      = '0;
        bankWrEn[backOf(frontSelect)] = backWrEn;
        bankRdEn[frontSelect]         = readEnable;
    end

    framebuffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bank0 (
        .clk    (clk),
        .resetN (resetN),
        .wrEn   (bankWrEn[BANK0]),
        .wrAddr (backWrAddr),
        .wrData (backWrData),
        .rdEn   (bankRdEn[BANK0]),
        .rdAddr (readAddress),
        .rdData (bank0RdData)
    );

    framebuffer_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bank1 (
        .clk    (clk),
        .resetN (resetN),
        .wrEn   (bankWrEn[BANK1]),
        .wrAddr (backWrAddr),
        .wrData (backWrData),
        .rdEn   (bankRdEn[BANK1]),
        .rdAddr (readAddress),
        .rdData (bank1RdData)
    );

    // Both bank read registers hold, so the last-read bank's value is shown
    assign readData = (readSel == BANK1) ? bank1RdData : bank0RdData;

endmodule

// File: tb/tb_double_framebuffer.sv
// Self-checking bench for double_framebuffer: directed scenarios followed by
// a randomized phase, all checked against a two-bank array model.
module tb_double_framebuffer;

    localparam int unsigned W  = 9;
    localparam int unsigned D  = 2048;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          resetN;
    logic          writeEnable;
    logic [AW-1:0] writeAddress;
    logic [W-1:0]  writeData;
    logic          writeReady;
    logic          readEnable;
    logic [AW-1:0] readAddress;
    logic [W-1:0]  readData;
    logic          readValid;
    logic          clearStart;
    logic [W-1:0]  clearValue;
    logic          clearBusy;
    logic          clearDone;
    logic          swapRequest;
    logic          vsync;
    logic          swapPending;
    logic          swapDone;
    logic          frontSelect;

    double_framebuffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .writeEnable  (writeEnable),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .writeReady   (writeReady),
        .readEnable   (readEnable),
        .readAddress  (readAddress),
        .readData     (readData),
        .readValid    (readValid),
        .clearStart   (clearStart),
        .clearValue   (clearValue),
        .clearBusy    (clearBusy),
        .clearDone    (clearDone),
        .swapRequest  (swapRequest),
        .vsync        (vsync),
        .swapPending  (swapPending),
        .swapDone     (swapDone),
        .frontSelect  (frontSelect)
    );

    always #5 clk = ~clk;

    // Reference model: bank contents, displayed bank, outstanding request
    logic [W-1:0] mem [2][D];
    int           mFront;
    bit           mPending;
    logic [W-1:0] lastRd;

    int total = 0;
    int bad   = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doWrite(input int addr, input logic [W-1:0] data);
        writeEnable  = 1'b1;
        writeAddress = AW'(addr);
        writeData    = data;
        mem[1 - mFront][addr] = data;
        cycle();
        writeEnable = 1'b0;
    endtask

    task automatic doSwap();
        swapRequest = 1'b1;
        cycle();
        swapRequest = 1'b0;
        check("swap_pending_set", swapPending, 1);
        vsync = 1'b1;
        cycle();
        vsync  = 1'b0;
        mFront = 1 - mFront;
        check("swap_done_pulse", swapDone, 1);
        check("swap_front", frontSelect, mFront);
        check("swap_pending_clr", swapPending, 0);
        cycle();
        check("swap_done_once", swapDone, 0);
    endtask

    // Stream reads over [lo,hi] of the front bank; returns mismatching words
    task automatic sweep(input int lo, input int hi, output int errs);
        errs = 0;
        readEnable = 1'b1;
        for (int a = lo; a <= hi; a++) begin
            readAddress = AW'(a);
            cycle();
            if (readData !== mem[mFront][a] || readValid !== 1'b1) errs++;
            lastRd = mem[mFront][a];
        end
        readEnable = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           busy, done, early, guard, errs, b;
        logic [W-1:0] v2, x;
        logic         wrRdyDuringClear;
        bit           exec, we, re, sr, vs;
        int           wa, ra;
        logic [W-1:0] wd;

        resetN = 1'b0;
        writeEnable = 0; writeAddress = '0; writeData = '0;
        readEnable = 0;  readAddress = '0;
        clearStart = 0;  clearValue = '0;
        swapRequest = 0; vsync = 0;
        mFront = 0; mPending = 0; lastRd = '0;

        // Reset values
        repeat (3) cycle();
        check("rst_readData", readData, 0);
        check("rst_readValid", readValid, 0);
        check("rst_clearDone", clearDone, 0);
        check("rst_swapDone", swapDone, 0);
        check("rst_swapPending", swapPending, 0);
        check("rst_frontSelect", frontSelect, 0);
        resetN = 1'b1;
        cycle();
        check("rst_writeReady", writeReady, 1);
        check("rst_clearBusy", clearBusy, 0);

        // Fill back bank with 0x0FF: busy for exactly D cycles, one done pulse
        b = 1 - mFront;
        clearValue = 9'h0FF;
        clearStart = 1'b1;
        cycle();
        clearStart = 1'b0;
        busy = 0; done = 0; guard = 0;
        while (clearBusy === 1'b1 && guard < 3 * D) begin
            busy++;
            if (clearDone === 1'b1) done++;
            cycle();
            guard++;
        end
        if (clearDone === 1'b1) done++;
        check("clr1_done_at_end", clearDone, 1);
        cycle();
        if (clearDone === 1'b1) done++;
        check("clr1_busy_cycles", busy, D);
        check("clr1_done_pulses", done, 1);
        for (int a = 0; a < int'(D); a++) mem[b][a] = 9'h0FF;

        // Write 0x1A5 to back addr 5, swap, read it from the new front
        doWrite(5, 9'h1A5);
        doSwap();
        readEnable = 1'b1;
        readAddress = AW'(5);
        cycle();
        readEnable = 1'b0;
        check("rd5_valid", readValid, 1);
        check("rd5_data", readData, 9'h1A5);
        cycle();
        check("rd_valid_drop", readValid, 0);
        check("rd_data_hold", readData, 9'h1A5);
        sweep(0, D - 1, errs);
        check("sweep_fill_0ff", errs, 0);

        // Fill with swap request + vsync held and a dropped write mid-fill
        b  = 1 - mFront;
        v2 = W'($urandom_range(0, 511));
        clearValue = v2;
        clearStart = 1'b1;
        cycle();
        clearStart = 1'b0;
        swapRequest = 1'b1;
        vsync = 1'b1;
        busy = 0; done = 0; early = 0; guard = 0;
        wrRdyDuringClear = 1'b1;
        while (clearBusy === 1'b1 && guard < 3 * D) begin
            busy++;
            if (clearDone === 1'b1) done++;
            if (swapDone === 1'b1) early++;
            if (busy == 50) begin
                writeEnable  = 1'b1;
                writeAddress = AW'(10);
                writeData    = ~v2;
                wrRdyDuringClear = writeReady;
            end else begin
                writeEnable = 1'b0;
            end
            cycle();
            guard++;
        end
        writeEnable = 1'b0;
        if (clearDone === 1'b1) done++;
        check("clr2_busy_cycles", busy, D);
        check("clr2_no_early_swap", early, 0);
        check("clr2_wready_low", wrRdyDuringClear, 0);
        check("clr2_swap_deferred", swapDone, 0);
        check("clr2_front_kept", frontSelect, mFront);
        check("clr2_pending_kept", swapPending, 1);
        cycle();
        if (clearDone === 1'b1) done++;
        mFront = 1 - mFront;
        check("clr2_swap_done", swapDone, 1);
        check("clr2_swap_front", frontSelect, mFront);
        check("clr2_req_absorbed", swapPending, 0);
        check("clr2_done_pulses", done, 1);
        swapRequest = 1'b0;
        vsync = 1'b0;
        for (int a = 0; a < int'(D); a++) mem[b][a] = v2;
        cycle();
        sweep(0, 63, errs);
        check("sweep_fill_rand", errs, 0);

        // Read addr 7 on the swap edge returns the old front data
        x = ~mem[mFront][7];
        doWrite(7, x);
        swapRequest = 1'b1;
        cycle();
        swapRequest = 1'b0;
        vsync = 1'b1;
        readEnable = 1'b1;
        readAddress = AW'(7);
        cycle();
        vsync = 1'b0;
        readEnable = 1'b0;
        check("rdswap_old_front", readData, mem[mFront][7]);
        check("rdswap_done", swapDone, 1);
        mFront = 1 - mFront;
        cycle();
        sweep(7, 7, errs);
        check("rdswap_new_front", readData, x);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 1) == 1);
            sr = ($urandom_range(0, 5) == 0);
            vs = ($urandom_range(0, 3) == 0);
            wa = int'($urandom_range(0, D - 1));
            ra = int'($urandom_range(0, D - 1));
            wd = W'($urandom_range(0, 511));
            writeEnable = we; writeAddress = AW'(wa); writeData = wd;
            readEnable = re;  readAddress = AW'(ra);
            swapRequest = sr; vsync = vs;
            if (re) lastRd = mem[mFront][ra];
            if (we) mem[1 - mFront][wa] = wd;
            exec = mPending && vs;
            if (exec) begin
                mFront = 1 - mFront;
                mPending = 0;
            end else if (sr) begin
                mPending = 1;
            end
            cycle();
            check("rnd_readValid", readValid, re);
            check("rnd_readData", readData, lastRd);
            check("rnd_frontSelect", frontSelect, mFront);
            check("rnd_swapDone", swapDone, exec);
            check("rnd_swapPending", swapPending, mPending);
        end
        writeEnable = 0; readEnable = 0; swapRequest = 0; vsync = 0;
        cycle();
        if (mPending) begin
            vsync = 1'b1;
            cycle();
            vsync = 1'b0;
            mFront = 1 - mFront;
            mPending = 0;
            cycle();
        end

        // Reset with the fill counter at 100
        b = 1 - mFront;
        clearValue = 9'h155;
        clearStart = 1'b1;
        cycle();
        clearStart = 1'b0;
        repeat (100) cycle();
        check("rst_mid_busy_before", clearBusy, 1);
        resetN = 1'b0;
        #1;
        check("rstmid_readData", readData, 0);
        check("rstmid_readValid", readValid, 0);
        check("rstmid_clearDone", clearDone, 0);
        check("rstmid_swapDone", swapDone, 0);
        check("rstmid_swapPending", swapPending, 0);
        check("rstmid_frontSelect", frontSelect, 0);
        repeat (2) cycle();
        resetN = 1'b1;
        cycle();
        check("rstmid_writeReady", writeReady, 1);
        check("rstmid_clearBusy", clearBusy, 0);
        for (int a = 0; a < 100; a++) mem[b][a] = 9'h155;
        mFront = 0;
        mPending = 0;
        if (b != 0) doSwap();
        sweep(0, 199, errs);
        check("rstmid_partial_fill", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
